// File: rtl/uart_pkg.sv
// Shared 8N1 UART definitions used by the receiver and the transmitter.
// Holds the receiver state encoding, frame constants and the baud divider helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } uart_state_e;

    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line.
// It resets to 1 so that a reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = rx;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign rx_s = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start detect, mid-bit sampling, stop check, 1-cycle result pulses.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each sample point.
//
// state   | meaning
// IDLE    | line idle, waiting for rx_s low
// START   | half a bit in, confirming the start bit
// DATA    | shifting in 8 data bits, LSB first
// STOP    | checking the stop bit at mid-bit
// WAIT_HI | framing error seen, waiting for the line to go high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 27000000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int          DIV     = baud_div(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int          HALF    = DIV / 2;
    localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(HALF - 1);
    localparam logic [2:0]  LAST_IX = 3'(DATA_BITS - 1);

    logic rx_s;
    logic sample;

    uart_state_e          state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [7:0]           data_q, data_d;
    logic                 data_valid_q, data_valid_d;
    logic                 frame_err_q, frame_err_d;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // Two-deep history of rx_s gives the P-2 and P-1 samples at the decision cycle P.
    logic [1:0] hist_q, hist_d;

    always_comb begin
        hist_d = {hist_q[0], rx_s};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    assign sample = rx_s;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 16'd1;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = 16'd0;
                    if (!sample) begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_q == DIV_M1) begin
                    cnt_d   = 16'd0;
                    shift_d = {sample, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == LAST_IX) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
                if (cnt_q == DIV_M1) begin
                    cnt_d = 16'd0;
                    if (sample) begin
                        data_d       = shift_q;
                        data_valid_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                cnt_d = 16'd0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = 16'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 16'd0;
            bit_idx_q    <= 3'd0;
            shift_q      <= '0;
            data_q       <= 8'd0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 27 MHz / 115200 baud, driving rx bit-accurately.
module tb_uart_rx;

    localparam int DIV  = 234;
    localparam int HALF = 117;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    int         cyc      = 0;
    int         dv_cnt   = 0;
    int         fe_cnt   = 0;
    int         both_cnt = 0;
    logic [7:0] dv_data  = 8'h00;
    int         dv_cyc   = 0;
    int         t_start  = 0;

    uart_rx #(
        .CLOCK_FREQUENCY (27000000),
        .BAUD_RATE       (115200)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_cnt  = dv_cnt + 1;
            dv_data = data;
            dv_cyc  = cyc;
        end
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (data_valid && frame_err) both_cnt = both_cnt + 1;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    // glitch_k selects a frame bit (0 = start) that gets a single low cycle at its mid-point.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int glitch_k);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < DIV; j++) begin
                @(negedge clk);
                rx = (k == glitch_k && j == HALF) ? 1'b0 : fr[k];
                if (k == 0 && j == 0) t_start = cyc;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h expected 00", data); end
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_dv: got %b expected 0", data_valid); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_fe: got %b expected 0", frame_err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        idle(10);
    endtask

    task automatic test_back_to_back;
        int dv0;
        int lat;
        dv0 = dv_cnt;
        send_frame(8'h55, 1'b1, -1);
        lat = dv_cyc - t_start;
        n_cmp++; if (dv_cnt - dv0 !== 1) begin n_bad++; $display("FAIL b2b_first_count: got %0d expected 1", dv_cnt - dv0); end
        n_cmp++; if (dv_data !== 8'h55) begin n_bad++; $display("FAIL b2b_first_data: got %h expected 55", dv_data); end
        n_cmp++; if (lat < 2224 || lat > 2226) begin n_bad++; $display("FAIL b2b_latency: got %0d expected 2224..2226", lat); end
        send_frame(8'hA3, 1'b1, -1);
        n_cmp++; if (dv_cnt - dv0 !== 2) begin n_bad++; $display("FAIL b2b_second_count: got %0d expected 2", dv_cnt - dv0); end
        n_cmp++; if (data !== 8'hA3) begin n_bad++; $display("FAIL b2b_second_data: got %h expected a3", data); end
        idle(DIV);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_frame_err;
        int dv0;
        int fe0;
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        send_frame(8'h00, 1'b0, -1);
        idle(DIV);
        n_cmp++; if (fe_cnt - fe0 !== 1) begin n_bad++; $display("FAIL ferr_count: got %0d expected 1", fe_cnt - fe0); end
        n_cmp++; if (dv_cnt - dv0 !== 0) begin n_bad++; $display("FAIL ferr_no_dv: got %0d expected 0", dv_cnt - dv0); end
        n_cmp++; if (data !== 8'hA3) begin n_bad++; $display("FAIL ferr_data_held: got %h expected a3", data); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ferr_busy: got %b expected 0", busy); end
    endtask

    task automatic test_glitch;
        int   dv0;
        int   fe0;
        logic busy_mid;
        dv0      = dv_cnt;
        fe0      = fe_cnt;
        busy_mid = 1'b0;
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            rx = 1'b0;
            if (j == 40) busy_mid = busy;
        end
        idle(2 * DIV);
        n_cmp++; if (busy_mid !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_mid: got %b expected 1", busy_mid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_after: got %b expected 0", busy); end
        n_cmp++; if ((dv_cnt - dv0) + (fe_cnt - fe0) !== 0) begin n_bad++; $display("FAIL glitch_no_pulse: got %0d pulses expected 0", (dv_cnt - dv0) + (fe_cnt - fe0)); end
    endtask

    task automatic test_break;
        int dv0;
        int fe0;
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        repeat (20 * DIV) begin
            @(negedge clk);
            rx = 1'b0;
        end
        idle(DIV);
        n_cmp++; if (fe_cnt - fe0 !== 1) begin n_bad++; $display("FAIL break_one_ferr: got %0d expected 1", fe_cnt - fe0); end
        n_cmp++; if (dv_cnt - dv0 !== 0) begin n_bad++; $display("FAIL break_no_dv: got %0d expected 0", dv_cnt - dv0); end
        send_frame(8'h7E, 1'b1, -1);
        n_cmp++; if (dv_cnt - dv0 !== 1) begin n_bad++; $display("FAIL break_recover_count: got %0d expected 1", dv_cnt - dv0); end
        n_cmp++; if (data !== 8'h7E) begin n_bad++; $display("FAIL break_recover_data: got %h expected 7e", data); end
    endtask

    task automatic test_reset_mid_frame;
        int         dv0;
        int         fe0;
        logic [9:0] fr;
        logic       busy_r;
        logic [7:0] data_r;
        dv0    = dv_cnt;
        fe0    = fe_cnt;
        fr     = {1'b1, 8'hFF, 1'b0};
        busy_r = 1'b1;
        data_r = 8'hXX;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < DIV; j++) begin
                @(negedge clk);
                rx = fr[k];
                if (k == 5) rst = (j < 5);
                if (k == 5 && j == 4) begin
                    busy_r = busy;
                    data_r = data;
                end
            end
        end
        idle(DIV);
        n_cmp++; if (busy_r !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy_in_reset: got %b expected 0", busy_r); end
        n_cmp++; if (data_r !== 8'h00) begin n_bad++; $display("FAIL rstmid_data_in_reset: got %h expected 00", data_r); end
        n_cmp++; if ((dv_cnt - dv0) + (fe_cnt - fe0) !== 0) begin n_bad++; $display("FAIL rstmid_no_pulse: got %0d pulses expected 0", (dv_cnt - dv0) + (fe_cnt - fe0)); end
        n_cmp++; if (data !== 8'h00) begin n_bad++; $display("FAIL rstmid_data_after: got %h expected 00", data); end
        send_frame(8'h81, 1'b1, -1);
        n_cmp++; if (dv_cnt - dv0 !== 1) begin n_bad++; $display("FAIL rstmid_next_count: got %0d expected 1", dv_cnt - dv0); end
        n_cmp++; if (data !== 8'h81) begin n_bad++; $display("FAIL rstmid_next_data: got %h expected 81", data); end
    endtask

    task automatic test_majority_glitch;
        int         dv0;
        logic [7:0] exp_data;
`ifdef UART_RX_MAJORITY_EN
        exp_data = 8'hFF;
`else
        exp_data = 8'hF7;
`endif
        dv0 = dv_cnt;
        send_frame(8'hFF, 1'b1, 4);
        idle(10);
        n_cmp++; if (dv_cnt - dv0 !== 1) begin n_bad++; $display("FAIL midglitch_count: got %0d expected 1", dv_cnt - dv0); end
        n_cmp++; if (data !== exp_data) begin n_bad++; $display("FAIL midglitch_data: got %h expected %h", data, exp_data); end
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        test_reset();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_break();
        test_reset_mid_frame();
        test_majority_glitch();
        n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL dv_fe_exclusive: got %0d overlaps expected 0", both_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
